// File: rtl/add3_pipe.sv
// add3_pipe: two-stage valid/ready adder pipeline, d = a + b then e = d + c, with overflow and done count.
// Define ADD3_PIPE_SAT_EN to saturate each add on signed overflow instead of wrapping.
module add3_pipe #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [WIDTH-1:0]   in_c,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_d,
    output logic [WIDTH-1:0]   out_e,
    output logic               out_ovf,
    output logic               ovf_sticky,
    input  logic               clr_ovf,
    output logic [COUNT_W-1:0] done_cnt
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_d;
    logic [WIDTH-1:0] s1_c;
    logic             s1_ovf;
    logic             s2_valid;

    logic             s2_ready;
    logic             s1_adv;
    logic             in_hs;
    logic             out_hs;

    logic [WIDTH-1:0] sum_ab;
    logic             ovf_ab;
    logic [WIDTH-1:0] d_next;
    logic [WIDTH-1:0] sum_dc;
    logic             ovf_dc;
    logic [WIDTH-1:0] e_next;

    assign s2_ready  = !s2_valid || out_ready;
    assign s1_adv    = s1_valid && s2_ready;
    assign in_ready  = !s1_valid || s2_ready;
    assign in_hs     = in_valid && in_ready;
    assign out_valid = s2_valid;
    assign out_hs    = s2_valid && out_ready;

    // Overflow: both operands share a sign the sum does not.
    assign sum_ab = in_a + in_b;
    assign ovf_ab = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum_ab[WIDTH-1] != in_a[WIDTH-1]);
    assign sum_dc = s1_d + s1_c;
    assign ovf_dc = (s1_d[WIDTH-1] == s1_c[WIDTH-1]) && (sum_dc[WIDTH-1] != s1_d[WIDTH-1]);

`ifdef ADD3_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // On overflow the operand sign tells which rail was crossed.
    assign d_next = ovf_ab ? (in_a[WIDTH-1] ? MIN_NEG : MAX_POS) : sum_ab;
    assign e_next = ovf_dc ? (s1_d[WIDTH-1] ? MIN_NEG : MAX_POS) : sum_dc;
`else
    assign d_next = sum_ab;
    assign e_next = sum_dc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_d     <= '0;
            s1_c     <= '0;
            s1_ovf   <= 1'b0;
        end else begin
            if (in_hs) begin
                s1_valid <= 1'b1;
                s1_d     <= d_next;
                s1_c     <= in_c;
                s1_ovf   <= ovf_ab;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_d    <= '0;
            out_e    <= '0;
            out_ovf  <= 1'b0;
        end else begin
            if (s1_adv) begin
                s2_valid <= 1'b1;
                out_d    <= s1_d;
                out_e    <= e_next;
                out_ovf  <= s1_ovf || ovf_dc;
            end else if (out_hs) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // Set beats clear when both happen on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
            done_cnt   <= '0;
        end else begin
            if (out_hs && out_ovf) begin
                ovf_sticky <= 1'b1;
            end else if (clr_ovf) begin
                ovf_sticky <= 1'b0;
            end
            if (out_hs) begin
                done_cnt <= done_cnt + {{(COUNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_add3_pipe.sv
// tb_add3_pipe: directed and randomized checks of add3_pipe against a wide-integer reference model.
// A second instance with a 4-bit counter exercises done_cnt wrap.
module tb_add3_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] in_c;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_d;
    logic [31:0] out_e;
    logic        out_ovf;
    logic        ovf_sticky;
    logic        clr_ovf;
    logic [15:0] done_cnt;

    logic        c4_in_ready;
    logic        c4_out_valid;
    logic [31:0] c4_out_d;
    logic [31:0] c4_out_e;
    logic        c4_out_ovf;
    logic        c4_ovf_sticky;
    logic [3:0]  c4_done_cnt;

    int checks   = 0;
    int failures = 0;

    add3_pipe #(.WIDTH(32), .COUNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .out_valid(out_valid),
        .out_ready(out_ready), .out_d(out_d), .out_e(out_e), .out_ovf(out_ovf),
        .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf), .done_cnt(done_cnt)
    );

    add3_pipe #(.WIDTH(32), .COUNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c4_in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .out_valid(c4_out_valid),
        .out_ready(out_ready), .out_d(c4_out_d), .out_e(c4_out_e), .out_ovf(c4_out_ovf),
        .ovf_sticky(c4_ovf_sticky), .clr_ovf(clr_ovf), .done_cnt(c4_done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: add in 64-bit signed space; overflow means the true sum leaves the 32-bit range.
    function automatic void ref_add3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                     output logic [31:0] d, output logic [31:0] e, output logic ovf);
        longint max_v = 64'sd2147483647;
        longint min_v = -64'sd2147483648;
        longint s1;
        longint s2;
        logic   o1;
        logic   o2;
        s1 = longint'($signed(a)) + longint'($signed(b));
        o1 = (s1 > max_v) || (s1 < min_v);
        d  = s1[31:0];
`ifdef ADD3_PIPE_SAT_EN
        if (o1) d = (s1 > max_v) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        s2 = longint'($signed(d)) + longint'($signed(c));
        o2 = (s2 > max_v) || (s2 < min_v);
        e  = s2[31:0];
`ifdef ADD3_PIPE_SAT_EN
        if (o2) e = (s2 > max_v) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        ovf = o1 || o2;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(3) == 0) begin
            case ($urandom_range(3))
                0: v = 32'h7FFF_FFFF;
                1: v = 32'h8000_0000;
                2: v = 32'hFFFF_FFFF;
                default: v = 32'h0000_0001;
            endcase
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_c     = c;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        clr_ovf   = 1'b0;
        out_ready = 1'b1;
        set_in(1'b0, 32'd0, 32'd0, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        clr_ovf   = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 32'd0, 32'd0, 32'd0);
        #2;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_d !== 32'd0 || out_e !== 32'd0 ||
            out_ovf !== 1'b0 || ovf_sticky !== 1'b0 || done_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_values: valid=%b ready=%b d=%h e=%h ovf=%b sticky=%b cnt=%0d, want 0 1 0 0 0 0 0",
                     out_valid, in_ready, out_d, out_e, out_ovf, ovf_sticky, done_cnt);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_sum();
        do_reset();
        set_in(1'b1, 32'd5, 32'd23, 32'd10);
        step();
        set_in(1'b0, 32'd0, 32'd0, 32'd0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_valid: out_valid=%b after 1 edge, want 0", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_d !== 32'd28 || out_e !== 32'd38 || out_ovf !== 1'b0 || done_cnt !== 16'd0) begin
            failures++;
            $display("FAIL basic_result: valid=%b d=%0d e=%0d ovf=%b cnt=%0d, want 1 28 38 0 0",
                     out_valid, out_d, out_e, out_ovf, done_cnt);
        end
        step();
        checks++;
        if (done_cnt !== 16'd1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_count: cnt=%0d valid=%b, want 1 0", done_cnt, out_valid);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_d1, exp_e1, exp_d2, exp_e2;
`ifdef ADD3_PIPE_SAT_EN
        exp_d1 = 32'h7FFF_FFFF; exp_e1 = 32'h7FFF_FFFF;
        exp_d2 = 32'h7FFF_FFFF; exp_e2 = 32'h7FFF_FFFE;
`else
        exp_d1 = 32'h8000_0000; exp_e1 = 32'h8000_0000;
        exp_d2 = 32'h8000_0000; exp_e2 = 32'h7FFF_FFFF;
`endif
        do_reset();
        set_in(1'b1, 32'h7FFF_FFFF, 32'd1, 32'd0);
        step();
        set_in(1'b0, 32'd0, 32'd0, 32'd0);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_d !== exp_d1 || out_e !== exp_e1 || out_ovf !== 1'b1 || ovf_sticky !== 1'b0) begin
            failures++;
            $display("FAIL ovf_pos: valid=%b d=%h e=%h ovf=%b sticky=%b, want 1 %h %h 1 0",
                     out_valid, out_d, out_e, out_ovf, ovf_sticky, exp_d1, exp_e1);
        end
        step();
        checks++;
        if (ovf_sticky !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky_set: sticky=%b, want 1", ovf_sticky);
        end
        set_in(1'b1, 32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFF);
        step();
        set_in(1'b0, 32'd0, 32'd0, 32'd0);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_d !== exp_d2 || out_e !== exp_e2 || out_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_cm1: valid=%b d=%h e=%h ovf=%b, want 1 %h %h 1",
                     out_valid, out_d, out_e, out_ovf, exp_d2, exp_e2);
        end
        step();
    endtask

    task automatic test_sticky_clear();
        do_reset();
        set_in(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        step();
        set_in(1'b0, 32'd0, 32'd0, 32'd0);
        step();
        clr_ovf = 1'b1;
        step();
        checks++;
        if (ovf_sticky !== 1'b1) begin
            failures++;
            $display("FAIL sticky_race: sticky=%b with set and clear together, want 1", ovf_sticky);
        end
        step();
        checks++;
        if (ovf_sticky !== 1'b0) begin
            failures++;
            $display("FAIL sticky_clear: sticky=%b after clear, want 0", ovf_sticky);
        end
        clr_ovf = 1'b0;
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int got = 0;
        logic ih, oh;
        logic [31:0] e_seen;
        do_reset();
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            set_in(idx < 4, idx + 1, idx + 1, idx + 1);
            #1;
            if (cyc == 2) begin
                checks++;
                if (in_ready !== 1'b0 || idx != 2) begin
                    failures++;
                    $display("FAIL bp_in_ready: in_ready=%b accepted=%0d, want 0 2", in_ready, idx);
                end
            end
            ih = in_valid && in_ready;
            step();
            if (ih) idx++;
            if (cyc >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_e !== 32'd3) begin
                    failures++;
                    $display("FAIL bp_hold_c%0d: valid=%b e=%0d, want 1 3", cyc, out_valid, out_e);
                end
            end
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            set_in(idx < 4, idx + 1, idx + 1, idx + 1);
            #1;
            ih = in_valid && in_ready;
            oh = out_valid && out_ready;
            e_seen = out_e;
            step();
            if (ih) idx++;
            if (oh) begin
                checks++;
                if (e_seen !== 32'(3 * (got + 1))) begin
                    failures++;
                    $display("FAIL bp_order_%0d: e=%0d, want %0d", got, e_seen, 3 * (got + 1));
                end
                got++;
            end
        end
        set_in(1'b0, 32'd0, 32'd0, 32'd0);
        checks++;
        if (got != 4 || done_cnt !== 16'd4) begin
            failures++;
            $display("FAIL bp_drain: outputs=%0d cnt=%0d, want 4 4", got, done_cnt);
        end
    endtask

    task automatic test_count_wrap();
        do_reset();
        set_in(1'b1, 32'd1, 32'd1, 32'd1);
        repeat (17) step();
        set_in(1'b0, 32'd0, 32'd0, 32'd0);
        repeat (3) step();
        checks++;
        if (c4_done_cnt !== 4'd1 || done_cnt !== 16'd17) begin
            failures++;
            $display("FAIL count_wrap: cnt4=%0d cnt16=%0d, want 1 17", c4_done_cnt, done_cnt);
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        set_in(1'b1, 32'd1, 32'd2, 32'd3);
        step();
        set_in(1'b1, 32'd4, 32'd5, 32'd6);
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || done_cnt !== 16'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midflight_reset: valid=%b cnt=%0d ready=%b, want 0 0 1", out_valid, done_cnt, in_ready);
        end
        set_in(1'b0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_in(1'b1, 32'd5, 32'd23, 32'd10);
        step();
        set_in(1'b0, 32'd0, 32'd0, 32'd0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midflight_early: valid=%b after 1 edge, want 0", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_e !== 32'd38 || out_d !== 32'd28) begin
            failures++;
            $display("FAIL midflight_result: valid=%b d=%0d e=%0d, want 1 28 38", out_valid, out_d, out_e);
        end
        step();
    endtask

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] e;
        logic        ovf;
    } result_t;

    task automatic test_random();
        result_t     q[$];
        result_t     exp_r;
        result_t     new_r;
        int          cnt = 0;
        logic        sticky_m = 1'b0;
        logic        stall_prev = 1'b0;
        logic [31:0] pd, pe;
        logic        po;
        logic        ih, oh;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            set_in($urandom_range(3) != 0, pick_operand(), pick_operand(), pick_operand());
            out_ready = ($urandom_range(3) != 0);
            clr_ovf   = ($urandom_range(7) == 0);
            #1;
            checks++;
            if (in_ready !== ((q.size() < 2) || out_ready)) begin
                failures++;
                $display("FAIL rnd_in_ready c%0d: ready=%b occ=%0d out_ready=%b", cyc, in_ready, q.size(), out_ready);
            end
            if (stall_prev) begin
                checks++;
                if (out_d !== pd || out_e !== pe || out_ovf !== po || out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL rnd_stall c%0d: d=%h e=%h ovf=%b valid=%b, want %h %h %b 1",
                             cyc, out_d, out_e, out_ovf, out_valid, pd, pe, po);
                end
            end
            ih = in_valid && in_ready;
            oh = out_valid && out_ready;
            if (oh) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_spurious c%0d: output handshake with empty model", cyc);
                end else begin
                    exp_r = q.pop_front();
                    if (out_d !== exp_r.d || out_e !== exp_r.e || out_ovf !== exp_r.ovf) begin
                        failures++;
                        $display("FAIL rnd_data c%0d: d=%h e=%h ovf=%b, want %h %h %b",
                                 cyc, out_d, out_e, out_ovf, exp_r.d, exp_r.e, exp_r.ovf);
                    end
                    if (exp_r.ovf) sticky_m = 1'b1;
                    else if (clr_ovf) sticky_m = 1'b0;
                    cnt++;
                end
            end else if (clr_ovf) begin
                sticky_m = 1'b0;
            end
            if (ih) begin
                ref_add3(in_a, in_b, in_c, new_r.d, new_r.e, new_r.ovf);
                q.push_back(new_r);
            end
            stall_prev = out_valid && !out_ready;
            pd = out_d;
            pe = out_e;
            po = out_ovf;
            step();
            checks++;
            if (ovf_sticky !== sticky_m || done_cnt !== cnt[15:0] || c4_done_cnt !== cnt[3:0]) begin
                failures++;
                $display("FAIL rnd_status c%0d: sticky=%b cnt=%0d cnt4=%0d, want %b %0d %0d",
                         cyc, ovf_sticky, done_cnt, c4_done_cnt, sticky_m, cnt[15:0], cnt[3:0]);
            end
        end
        set_in(1'b0, 32'd0, 32'd0, 32'd0);
        out_ready = 1'b1;
        clr_ovf   = 1'b0;
        for (int cyc = 0; cyc < 10 && q.size() != 0; cyc++) begin
            #1;
            if (out_valid) begin
                exp_r = q.pop_front();
                checks++;
                if (out_e !== exp_r.e || out_d !== exp_r.d || out_ovf !== exp_r.ovf) begin
                    failures++;
                    $display("FAIL rnd_drain: d=%h e=%h ovf=%b, want %h %h %b",
                             out_d, out_e, out_ovf, exp_r.d, exp_r.e, exp_r.ovf);
                end
            end
            step();
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL rnd_leftover: %0d results never appeared, want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_overflow();
        test_sticky_clear();
        test_backpressure();
        test_count_wrap();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add3_pipe.md
Name: add3_pipe

Overview:
- Two-stage valid/ready arithmetic pipeline.
- Stage 1 computes d = a + b. Stage 2 computes e = d + c.
- It is the registered, synthesizable form of the blocking/non-blocking sum sequence in the Basics assignment examples.
- It consumes operand triples from an upstream stimulus/producer and feeds a downstream consumer. It reports overflow and a completed-transaction count.

Parameters:
- WIDTH, 32, operand and result width; signed two's complement (matches int).
- COUNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand triple valid.
- in_ready  output  1  pipeline can accept the triple this cycle.
- in_a  input  WIDTH  operand a, signed.
- in_b  input  WIDTH  operand b, signed.
- in_c  input  WIDTH  operand c, signed.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_d  output  WIDTH  partial sum a+b carried with the result.
- out_e  output  WIDTH  final sum (a+b)+c.
- out_ovf  output  1  signed overflow occurred in either add of this result.
- ovf_sticky  output  1  latched overflow, held until cleared.
- clr_ovf  input  1  synchronous clear of ovf_sticky.
- done_cnt  output  COUNT_W  number of output handshakes, wrapping.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. Everything below is sampled on the clk rising edge unless stated.
- Reset values:
  - out_valid=0, in_ready=1 (combinational once s1 is empty).
  - out_d=0, out_e=0, out_ovf=0, ovf_sticky=0, done_cnt=0.
  - All internal stage valids and data cleared.
- Handshakes:
  - Input handshake = in_valid & in_ready.
  - Output handshake = out_valid & out_ready.
- Stage 1 (s1): on input handshake it registers d=a+b (WIDTH bits), c, and ovf1.
  - ovf1 = a and b have equal sign and d's sign differs.
- Stage 2 (s2): on advance it registers e=d+c, d, and ovf = ovf1 | ovf2.
  - ovf2 uses the same sign rule applied to d and c.
- Ready chain, combinational, with no combinational path from in_valid to in_ready:
  - s2_ready = !s2_valid | out_ready.
  - s1 advances when s1_valid & s2_ready.
  - in_ready = !s1_valid | s2_ready.
- Valid updates per edge:
  - s1_valid <= input handshake ? 1 : (s1 advance ? 0 : s1_valid).
  - s2_valid <= s1 advance ? 1 : (output handshake ? 0 : s2_valid).
- Latency: 2 cycles from the input handshake edge to out_valid, with out_ready held high. Throughput is 1 triple per cycle.
- Stall: while out_valid & !out_ready, out_d, out_e and out_ovf stay stable. With both stages full, in_ready=0. No data is dropped or reordered.
- Arithmetic: results wrap modulo 2^WIDTH. There is no widening; the overflow flags report the loss.
- ovf_sticky:
  - Set on an output handshake with out_ovf=1.
  - Cleared by clr_ovf.
  - If set and clear happen in the same cycle, set wins.
- done_cnt: +1 on each output handshake. Wraps from 2^COUNT_W-1 to 0 with no flag.
- Reset mid-operation: in-flight triples are discarded immediately (asynchronously). out_valid drops in the same instant. The first post-reset input behaves as from idle.
- X-handling: data registers load only on handshake or advance. Operand values are ignored when in_valid=0.

Optional Feature:
- Macro: ADD3_PIPE_SAT_EN.
- Defined:
  - Each add saturates to +2^(WIDTH-1)-1 or -2^(WIDTH-1) when its overflow flag is set.
  - The saturated d feeds stage 2.
  - out_ovf and ovf_sticky are reported as normal.
- Undefined: two's-complement wrap as specified above.
- Latency and handshake are identical in both builds.

Test Plan:
- Basic sum: a=5,b=23,c=10, single beat, out_ready=1 -> out_valid exactly 2 cycles later with out_d=28, out_e=38, out_ovf=0, done_cnt=1.
- Overflow: a=0x7FFFFFFF,b=1,c=0 -> out_e=0x80000000, out_ovf=1, ovf_sticky=1 after the handshake. With ADD3_PIPE_SAT_EN: out_d=out_e=0x7FFFFFFF. Second case with c=-1 and wrap build: out_e=0x7FFFFFFF, out_ovf=1.
- Backpressure: 4 back-to-back triples (1,1,1),(2,2,2),(3,3,3),(4,4,4) with out_ready=0 for 5 cycles:
  - in_ready falls after 2 accepts; triple 3 stays held by the source.
  - Output holds e=3, stable.
  - After release, outputs 3,6,9,12 appear in order; done_cnt=4.
- Sticky clear race: clr_ovf=1 in the same cycle as an overflowing output handshake -> ovf_sticky=1. clr_ovf=1 in the next cycle -> ovf_sticky=0.
- Counter wrap: COUNT_W=4, 17 output handshakes -> done_cnt=1.
- Reset mid-flight: 2 triples in flight, assert rst between edges -> out_valid=0 and done_cnt=0 immediately, in_ready=1. After release, (5,23,10) yields 38 at 2-cycle latency.
